u_lsu_ctrl: RTL

// Load/store sequencer in the EXE stage. Takes a decoded LD/ST plus rs1/rs2/imm.

---
 rtl/u_lsu_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/u_lsu_ctrl.sv
// Load/store sequencer for the EXE stage: one data-bus transaction per LD/ST,
// load-data formatting and writeback, and fault reporting to the CSR block.
module u_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        i_LD,
  input  logic        i_ST,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_a,
  input  logic [31:0] imm,
  input  logic [31:0] rf_rs1_o,
  input  logic [31:0] rf_rs2_o,
  output logic        ex_stall,
  output logic        ls_done,
  output logic        rf_rd_e,
  output logic [4:0]  rf_rd_a,
  output logic [31:0] rf_rd_i,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err,
  output logic        exc_valid,
  output logic [2:0]  exc_cause,
  output logic [31:0] exc_tval
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      ea_q, ea_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      ldata_q, ldata_d;
  logic             exc_q, exc_d;
  logic [2:0]       cause_q, cause_d;

  logic [31:0] ea;
  logic        accept;
  logic        acc_illegal;
  logic        acc_misal;

  function automatic logic illegal_f(input logic ld, input logic [2:0] f3);
    if (ld) illegal_f = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    else    illegal_f = (f3 > 3'd2);
  endfunction

  function automatic logic misaligned_f(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd1:    misaligned_f = off[0];
      2'd2:    misaligned_f = (off != 2'd0);
      default: misaligned_f = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    be_f = 4'b0001 << off;
      2'd1:    be_f = 4'b0011 << off;
      default: be_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    wdata_f = {4{d[7:0]}};
      2'd1:    wdata_f = {2{d[15:0]}};
      default: wdata_f = d;
    endcase
  endfunction

  // Words are always lane-aligned, so the shifted lane equals rdata for W.
  function automatic logic [31:0] format_f(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [31:0] lane;
    lane = d >> {off, 3'b000};
    case (f3)
      3'd0:    format_f = {{24{lane[7]}}, lane[7:0]};
      3'd1:    format_f = {{16{lane[15]}}, lane[15:0]};
      3'd4:    format_f = {24'd0, lane[7:0]};
      3'd5:    format_f = {16'd0, lane[15:0]};
      default: format_f = lane;
    endcase
  endfunction

  assign ea          = rf_rs1_o + imm;
  assign accept      = (state_q == S_IDLE) && ex_valid && (i_LD || i_ST);
  assign acc_illegal = illegal_f(i_LD, funct3);
  assign acc_misal   = misaligned_f(funct3[1:0], ea[1:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    ea_d     = ea_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ld_d     = i_LD;
          funct3_d = funct3;
          rd_d     = rd_a;
          ea_d     = ea;
          be_d     = be_f(funct3[1:0], ea[1:0]);
          wdata_d  = wdata_f(funct3[1:0], rf_rs2_o);
          cnt_d    = '0;
          if (acc_illegal || acc_misal) begin
            state_d = S_FAULT;
            exc_d   = 1'b1;
            cause_d = acc_illegal ? 3'd4 : (i_LD ? 3'd0 : 3'd1);
          end else begin
            state_d = S_REQ;
            exc_d   = 1'b0;
          end
        end
      end
      // A grant on the final budgeted REQ cycle cannot complete in time.
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          exc_d   = 1'b1;
          cause_d = ld_q ? 3'd2 : 3'd3;
        end else if (dbus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dbus_rvalid) begin
          state_d = S_RESP;
          exc_d   = dbus_err;
          cause_d = ld_q ? 3'd2 : 3'd3;
          ldata_d = format_f(funct3_q, ea_q[1:0], dbus_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          exc_d   = 1'b1;
          cause_d = ld_q ? 3'd2 : 3'd3;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only control state is reset; every output is qualified by the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    ld_q     <= ld_d;
    funct3_q <= funct3_d;
    rd_q     <= rd_d;
    ea_q     <= ea_d;
    be_q     <= be_d;
    wdata_q  <= wdata_d;
    ldata_q  <= ldata_d;
    exc_q    <= exc_d;
    cause_q  <= cause_d;
  end

  always_comb begin
    ex_stall   = accept || (state_q == S_REQ) || (state_q == S_WAIT);
    ls_done    = (state_q == S_RESP) || (state_q == S_FAULT);
    exc_valid  = ls_done && exc_q;
    exc_cause  = exc_valid ? cause_q : 3'd0;
    exc_tval   = exc_valid ? ea_q : 32'd0;
    rf_rd_e    = (state_q == S_RESP) && ld_q && !exc_q && (rd_q != 5'd0);
    rf_rd_a    = rf_rd_e ? rd_q : 5'd0;
    rf_rd_i    = rf_rd_e ? ldata_q : 32'd0;
    dbus_req   = (state_q == S_REQ);
    dbus_we    = dbus_req && !ld_q;
    dbus_addr  = dbus_req ? {ea_q[31:2], 2'b00} : 32'd0;
    dbus_be    = dbus_req ? be_q : 4'd0;
    dbus_wdata = dbus_we ? wdata_q : 32'd0;
  end

endmodule
